gray_codec_pipe: RTL and testbench

- Parametrised, registered successor to the 3-bit combinational binary-to-Gray converter.
- Converts WIDTH-bit binary to Gray, or Gray to binary, selected per transfer by mode.
- A third mode generates a free-running Gray count sequence with a wrap flag.
- Valid/ready handshake on input and output, one-entry output register, sits between a producer (counter or encoder) and a downstream consumer.

---
 rtl/gray_codec_pipe.sv | 93 +++++++++
 tb/tb_gray_codec_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// Registered binary<->Gray codec with a free-running Gray counter mode.
// A valid/ready handshake wraps a one-entry output register, giving one result per cycle.
module gray_codec_pipe #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] in_data,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_wrap
);

   localparam logic [1:0] MODE_G2B = 2'b01;
   localparam logic [1:0] MODE_CNT = 2'b10;

   logic             valid_q, valid_d;
   logic             wrap_q, wrap_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] g2b;
   logic             accept;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Gray-to-binary prefix XOR, MSB down to LSB
   always_comb begin
      g2b = '0;
      g2b[WIDTH-1] = in_data[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         g2b[i] = g2b[i+1] ^ in_data[i];
      end
   end

   always_comb begin
      valid_d = valid_q;
      wrap_d  = wrap_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (accept) begin
         valid_d = 1'b1;
         case (mode)
            MODE_G2B: begin
               data_d = g2b;
               wrap_d = 1'b0;
            end
            MODE_CNT: begin
               // clr emits gray(0) and primes the counter so the next result is gray(1)
               if (clr) begin
                  data_d = '0;
                  wrap_d = 1'b0;
                  cnt_d  = WIDTH'(1);
               end else begin
                  data_d = cnt_q ^ (cnt_q >> 1);
                  wrap_d = (cnt_q == '1);
                  cnt_d  = cnt_q + WIDTH'(1);
               end
            end
            default: begin
               data_d = in_data ^ (in_data >> 1);
               wrap_d = 1'b0;
            end
         endcase
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_wrap  = wrap_q;

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe: a WIDTH=3 and a WIDTH=8 instance share clock and reset.
module tb_gray_codec_pipe;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       v3, ir3, c3, ov3, or3, w3;
   logic [1:0] m3;
   logic [2:0] d3, od3;

   logic       v8, ir8, c8, ov8, or8, w8;
   logic [1:0] m8;
   logic [7:0] d8, od8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gray_codec_pipe #(.WIDTH(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .mode(m3),
      .in_data(d3), .clr(c3), .out_valid(ov3), .out_ready(or3),
      .out_data(od3), .out_wrap(w3));

   gray_codec_pipe #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .mode(m8),
      .in_data(d8), .clr(c8), .out_valid(ov8), .out_ready(or8),
      .out_data(od8), .out_wrap(w8));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      v3 = 1'b0; c3 = 1'b0; or3 = 1'b1;
      v8 = 1'b0; c8 = 1'b0; or8 = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      v3 = 1'b0; m3 = 2'b00; d3 = '0; c3 = 1'b0; or3 = 1'b1;
      v8 = 1'b0; m8 = 2'b00; d8 = '0; c8 = 1'b0; or8 = 1'b1;
      tick();
      tick();
      checks++;
      if (ov3 !== 1'b0 || od3 !== 3'd0 || w3 !== 1'b0) begin
         failures++;
         $display("FAIL reset_w3: valid=%b data=%0d wrap=%b, want 0/0/0", ov3, od3, w3);
      end
      checks++;
      if (ov8 !== 1'b0 || od8 !== 8'd0 || w8 !== 1'b0 || ir8 !== 1'b1) begin
         failures++;
         $display("FAIL reset_w8: valid=%b data=%0d wrap=%b ready=%b, want 0/0/0/1", ov8, od8, w8, ir8);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_b2g();
      logic [2:0] exp [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      or3 = 1'b1; m3 = 2'b00; v3 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d3 = 3'(i);
         tick();
         checks++;
         if (ov3 !== 1'b1 || od3 !== exp[i] || w3 !== 1'b0) begin
            failures++;
            $display("FAIL b2g[%0d]: valid=%b data=%b wrap=%b, want 1/%b/0", i, ov3, od3, w3, exp[i]);
         end
      end
      // reserved mode 11 behaves like bin->gray
      m3 = 2'b11; d3 = 3'b110;
      tick();
      checks++;
      if (od3 !== 3'b101) begin
         failures++;
         $display("FAIL b2g_mode11: data=%b, want 101", od3);
      end
      idle();
   endtask

   task automatic test_g2b();
      m3 = 2'b01; v3 = 1'b1; d3 = 3'b111;
      tick();
      checks++;
      if (od3 !== 3'b101 || ov3 !== 1'b1) begin
         failures++;
         $display("FAIL g2b_111: data=%b valid=%b, want 101/1", od3, ov3);
      end
      d3 = 3'b100;
      tick();
      checks++;
      if (od3 !== 3'b111) begin
         failures++;
         $display("FAIL g2b_100: data=%b, want 111", od3);
      end
      m8 = 2'b01; v8 = 1'b1; d8 = 8'hC0;
      v3 = 1'b0;
      tick();
      checks++;
      if (od8 !== 8'h80 || ov8 !== 1'b1) begin
         failures++;
         $display("FAIL g2b_c0: data=%h valid=%b, want 80/1", od8, ov8);
      end
      idle();
   endtask

   task automatic test_count_wrap();
      logic [2:0] exp [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      m3 = 2'b10; v3 = 1'b1; c3 = 1'b0; d3 = 3'b111;
      for (int i = 0; i < 9; i++) begin
         tick();
         checks++;
         if (od3 !== exp[i] || w3 !== (i == 7) || ov3 !== 1'b1) begin
            failures++;
            $display("FAIL count[%0d]: data=%b wrap=%b valid=%b, want %b/%b/1", i, od3, w3, ov3, exp[i], (i == 7));
         end
      end
      tick();
      checks++;
      if (od3 !== 3'b001 || w3 !== 1'b0) begin
         failures++;
         $display("FAIL count_after_wrap: data=%b wrap=%b, want 001/0", od3, w3);
      end
      idle();
   endtask

   task automatic test_backpressure();
      m8 = 2'b00; d8 = 8'h05; v8 = 1'b1; or8 = 1'b1;
      tick();
      or8 = 1'b0; d8 = 8'h10; m8 = 2'b01;
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (od8 !== 8'h07 || ov8 !== 1'b1 || ir8 !== 1'b0) begin
            failures++;
            $display("FAIL stall[%0d]: data=%h valid=%b in_ready=%b, want 07/1/0", i, od8, ov8, ir8);
         end
         tick();
      end
      m8 = 2'b00; or8 = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin
         failures++;
         $display("FAIL stall_release_ready: in_ready=%b, want 1", ir8);
      end
      tick();
      v8 = 1'b0;
      checks++;
      if (od8 !== 8'h18 || ov8 !== 1'b1) begin
         failures++;
         $display("FAIL stall_next: data=%h valid=%b, want 18/1", od8, ov8);
      end
      tick();
      checks++;
      if (ov8 !== 1'b0 || od8 !== 8'h18) begin
         failures++;
         $display("FAIL pop_idle: valid=%b data=%h, want 0/18", ov8, od8);
      end
   endtask

   task automatic test_interleave();
      m8 = 2'b10; v8 = 1'b1; c8 = 1'b0; or8 = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (od8 !== 8'h02) begin
         failures++;
         $display("FAIL inter_count3: data=%h, want 02", od8);
      end
      m8 = 2'b00; d8 = 8'hFF; c8 = 1'b1;
      tick();
      checks++;
      if (od8 !== 8'h80 || w8 !== 1'b0) begin
         failures++;
         $display("FAIL inter_b2g_ff: data=%h wrap=%b, want 80/0", od8, w8);
      end
      m8 = 2'b10; c8 = 1'b0;
      tick();
      checks++;
      if (od8 !== 8'h06) begin
         failures++;
         $display("FAIL inter_count4: data=%h, want 06", od8);
      end
      c8 = 1'b1;
      tick();
      checks++;
      if (od8 !== 8'h00 || w8 !== 1'b0) begin
         failures++;
         $display("FAIL inter_clr: data=%h wrap=%b, want 00/0", od8, w8);
      end
      c8 = 1'b0;
      tick();
      checks++;
      if (od8 !== 8'h01) begin
         failures++;
         $display("FAIL inter_after_clr: data=%h, want 01", od8);
      end
      idle();
   endtask

   task automatic test_async_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m3 = 2'b10; v3 = 1'b1; c3 = 1'b0; or3 = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      v3 = 1'b0;
      checks++;
      if (od3 !== 3'b110 || ov3 !== 1'b1) begin
         failures++;
         $display("FAIL areset_pre: data=%b valid=%b, want 110/1", od3, ov3);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ov3 !== 1'b0 || od3 !== 3'b000 || w3 !== 1'b0) begin
         failures++;
         $display("FAIL areset_now: valid=%b data=%b wrap=%b, want 0/000/0", ov3, od3, w3);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (ov3 !== 1'b0) begin
         failures++;
         $display("FAIL areset_noreplay: valid=%b, want 0", ov3);
      end
      v3 = 1'b1;
      tick();
      checks++;
      if (od3 !== 3'b000 || ov3 !== 1'b1) begin
         failures++;
         $display("FAIL areset_first: data=%b valid=%b, want 000/1", od3, ov3);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_b2g();
      test_g2b();
      test_count_wrap();
      test_backpressure();
      test_interleave();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
